ddr2_cmd_arbiter: RTL

- Owns the single DDR2 command/address bus after power-up.
- Passes the power-up init sequencer's outputs straight through until init completes.
- Then arbitrates bus ownership between three requesters: auto-refresh, write engine and read engine.
- Each requester holds the bus for a complete burst, from grant until its end pulse. All bus outputs are registered.

---
 rtl/ddr2_cmd_arbiter_pkg.sv | 38 +++
 rtl/ddr2_arb_prio.sv | 57 +++++
 rtl/ddr2_cmd_arbiter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ddr2_cmd_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ddr2_cmd_arbiter_pkg
//
// Shared definitions for the DDR2 command-bus arbiter:
//   - default bank/address widths
//   - DDR2 command encodings, driven as {cs_n, ras_n, cas_n, we_n}
//   - arbiter FSM state encoding
//   - one-hot grant bundle passed from the priority select to the FSM
// ----------------------------------------------------------------------------
package ddr2_cmd_arbiter_pkg;

    localparam int DDR_BA_BITS   = 3;
    localparam int DDR_ADDR_BITS = 13;

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LM   = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_AREF = 3'd2,
        S_WR   = 3'd3,
        S_RD   = 3'd4
    } arb_state_e;

    // At most one bit set.
    typedef struct packed {
        logic aref;
        logic wr;
        logic rd;
    } grant_t;

endpackage

// File: rtl/ddr2_arb_prio.sv
// ----------------------------------------------------------------------------
// ddr2_arb_prio
//
// Combinational bus-owner select for the DDR2 command arbiter.
// Refresh always wins. Between write and read the choice depends on the build:
//   DDR2_ARB_ROUND_ROBIN_EN defined   : when both are pending, the one not
//                                       served last wins (last_wr_i = 1 means
//                                       the last wr/rd grant went to write).
//   DDR2_ARB_ROUND_ROBIN_EN undefined : fixed priority, write over read;
//                                       last_wr_i is ignored.
//
// Ports:
//   aref_req_i  refresh request level
//   wr_req_i    write request level
//   rd_req_i    read request level
//   last_wr_i   1 when the most recent wr/rd grant was a write
//   grant_o     one-hot grant (all zero when nothing is requested)
// ----------------------------------------------------------------------------
module ddr2_arb_prio
    import ddr2_cmd_arbiter_pkg::*;
(
    input  logic   aref_req_i,
    input  logic   wr_req_i,
    input  logic   rd_req_i,
    input  logic   last_wr_i,
    output grant_t grant_o
);

    // High when a simultaneous wr/rd contention should go to the read side.
    logic rd_turn;

`ifdef DDR2_ARB_ROUND_ROBIN_EN
    assign rd_turn = last_wr_i;
`else
    assign rd_turn = 1'b0;
    logic unused_last_wr;
    assign unused_last_wr = last_wr_i;
`endif

    always_comb begin
        grant_o = '0;
        if (aref_req_i) begin
            grant_o.aref = 1'b1;
        end else if (wr_req_i && rd_req_i) begin
            if (rd_turn) begin
                grant_o.rd = 1'b1;
            end else begin
                grant_o.wr = 1'b1;
            end
        end else if (wr_req_i) begin
            grant_o.wr = 1'b1;
        end else if (rd_req_i) begin
            grant_o.rd = 1'b1;
        end
    end

endmodule

// File: rtl/ddr2_cmd_arbiter.sv
// ----------------------------------------------------------------------------
// ddr2_cmd_arbiter
//
// Owner of the single DDR2 command/address bus. After reset the power-up init
// sequencer's signals are passed through (one clock late) until init_end.
// From then on CKE is held high and the bus is lent, one whole burst at a
// time, to auto-refresh, the write engine or the read engine.
//
// Handshake (all three requesters): *_req is a level held until *_ack; *_ack
// is a one-cycle pulse issued on the edge the FSM enters the owner's state;
// the requester drops *_req within one cycle of *_ack; the owner pulses
// *_end for one cycle to hand the bus back. *_end from a non-owner is ignored
// and ownership is never pre-empted. Returning to S_IDLE always costs one NOP
// cycle on the bus before the next grant.
//
// Build option: DDR2_ARB_ROUND_ROBIN_EN alternates write/read grants under
// contention (see ddr2_arb_prio); default build is fixed write-over-read.
//
// Ports:
//   ck, rst_n                      clock, asynchronous active-low reset
//   init_cke/cmd/ba/addr, init_end init sequencer bus and completion level
//   aref_req/ack/end/cmd/addr      refresh requester (bank address forced 0)
//   wr_req/ack/end/cmd/ba/addr     write engine
//   rd_req/ack/end/cmd/ba/addr     read engine
//   ddr_cke/cmd/ba/addr            registered DDR2 pad outputs
// ----------------------------------------------------------------------------
module ddr2_cmd_arbiter
    import ddr2_cmd_arbiter_pkg::*;
#(
    parameter int BA_BITS   = DDR_BA_BITS,
    parameter int ADDR_BITS = DDR_ADDR_BITS
) (
    input  logic                 ck,
    input  logic                 rst_n,

    input  logic                 init_cke,
    input  logic [3:0]           init_cmd,
    input  logic [BA_BITS-1:0]   init_ba,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic                 init_end,

    input  logic                 aref_req,
    output logic                 aref_ack,
    input  logic                 aref_end,
    input  logic [3:0]           aref_cmd,
    input  logic [ADDR_BITS-1:0] aref_addr,

    input  logic                 wr_req,
    output logic                 wr_ack,
    input  logic                 wr_end,
    input  logic [3:0]           wr_cmd,
    input  logic [BA_BITS-1:0]   wr_ba,
    input  logic [ADDR_BITS-1:0] wr_addr,

    input  logic                 rd_req,
    output logic                 rd_ack,
    input  logic                 rd_end,
    input  logic [3:0]           rd_cmd,
    input  logic [BA_BITS-1:0]   rd_ba,
    input  logic [ADDR_BITS-1:0] rd_addr,

    output logic                 ddr_cke,
    output logic [3:0]           ddr_cmd,
    output logic [BA_BITS-1:0]   ddr_ba,
    output logic [ADDR_BITS-1:0] ddr_addr
);

    arb_state_e           state_q, state_d;
    logic                 cke_q, cke_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [BA_BITS-1:0]   ba_q, ba_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 aref_ack_q, aref_ack_d;
    logic                 wr_ack_q, wr_ack_d;
    logic                 rd_ack_q, rd_ack_d;
    logic                 last_wr_q, last_wr_d;
    grant_t               grant;

    ddr2_arb_prio u_prio (
        .aref_req_i (aref_req),
        .wr_req_i   (wr_req),
        .rd_req_i   (rd_req),
        .last_wr_i  (last_wr_q),
        .grant_o    (grant)
    );

    always_comb begin
        state_d    = state_q;
        cke_d      = cke_q;
        cmd_d      = cmd_q;
        ba_d       = ba_q;
        addr_d     = addr_q;
        aref_ack_d = 1'b0;
        wr_ack_d   = 1'b0;
        rd_ack_d   = 1'b0;
        last_wr_d  = last_wr_q;

        case (state_q)
            S_INIT: begin
                cke_d  = init_cke;
                cmd_d  = init_cmd;
                ba_d   = init_ba;
                addr_d = init_addr;
                if (init_end) begin
                    state_d = S_IDLE;
                end
            end

            // ba/addr keep their last values; only the command goes to NOP.
            S_IDLE: begin
                cke_d = 1'b1;
                cmd_d = CMD_NOP;
                if (grant.aref) begin
                    aref_ack_d = 1'b1;
                    state_d    = S_AREF;
                end else if (grant.wr) begin
                    wr_ack_d  = 1'b1;
                    last_wr_d = 1'b1;
                    state_d   = S_WR;
                end else if (grant.rd) begin
                    rd_ack_d  = 1'b1;
                    last_wr_d = 1'b0;
                    state_d   = S_RD;
                end
            end

            S_AREF: begin
                cmd_d  = aref_cmd;
                ba_d   = '0;
                addr_d = aref_addr;
                if (aref_end) begin
                    state_d = S_IDLE;
                end
            end

            S_WR: begin
                cmd_d  = wr_cmd;
                ba_d   = wr_ba;
                addr_d = wr_addr;
                if (wr_end) begin
                    state_d = S_IDLE;
                end
            end

            S_RD: begin
                cmd_d  = rd_cmd;
                ba_d   = rd_ba;
                addr_d = rd_addr;
                if (rd_end) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_INIT;
            cke_q      <= 1'b0;
            cmd_q      <= CMD_NOP;
            ba_q       <= '0;
            addr_q     <= '0;
            aref_ack_q <= 1'b0;
            wr_ack_q   <= 1'b0;
            rd_ack_q   <= 1'b0;
            last_wr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cke_q      <= cke_d;
            cmd_q      <= cmd_d;
            ba_q       <= ba_d;
            addr_q     <= addr_d;
            aref_ack_q <= aref_ack_d;
            wr_ack_q   <= wr_ack_d;
            rd_ack_q   <= rd_ack_d;
            last_wr_q  <= last_wr_d;
        end
    end

    assign aref_ack = aref_ack_q;
    assign wr_ack   = wr_ack_q;
    assign rd_ack   = rd_ack_q;
    assign ddr_cke  = cke_q;
    assign ddr_cmd  = cmd_q;
    assign ddr_ba   = ba_q;
    assign ddr_addr = addr_q;

endmodule
